dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
Shares the single DRAM/cache port between instruction fetch (IF) and the MEM stage (loads/stores).
- Latches one request at a time and drives the DRAM handshake.
- Returns read data to the granted requester with a one-cycle ready pulse.
- MEM has priority. A bounded-burst counter keeps IF from starving.
- Discards a fetch response that a pipeline flush has made stale.

Parameters:
MEM_BURST_MAX, 4, consecutive MEM grants allowed while IF is pending before IF is forced to win (must be >= 1)
ADDR_W, 64, address width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  IF fetch request; held high until if_ready or flush
if_addr  input  ADDR_W  fetch address (bit 2 selects the word)
if_flush  input  1  pipeline flush; kills pending or in-flight fetch
if_data  output  32  fetched instruction
if_ready  output  1  one-cycle pulse; if_data valid
mem_req  input  1  MEM request; held until mem_ready
mem_we  input  1  1 = store, 0 = load
mem_addr  input  ADDR_W  data address
mem_wdata  input  64  store data
mem_wmask  input  8  byte enables for store
mem_rdata  output  64  load data
mem_ready  output  1  one-cycle pulse; load data valid / store done
dram_req  output  1  request to DRAM, held until dram_ready
dram_we  output  1  write enable to DRAM
dram_addr  output  ADDR_W  address to DRAM
dram_wdata  output  64  write data
dram_wmask  output  8  write byte mask (0 for reads)
dram_rdata  input  64  DRAM read data, valid with dram_ready
dram_ready  input  1  DRAM completion strobe
busy  output  1  high in any state other than IDLE

Behaviour:
States:
- IDLE: no transaction in progress.
- BUSY_IF / BUSY_MEM: DRAM transaction in flight for IF or MEM.
- RESP: one-cycle response state after completion.

Arbitration (evaluated only in IDLE):
- Normally MEM wins over IF.
- burst_cnt counts consecutive MEM grants made while if_req is high.
- If if_req is high and burst_cnt == MEM_BURST_MAX, IF wins.
- Any IF grant clears burst_cnt. An IDLE cycle with if_req low also clears it.
- if_req qualified by if_flush in the same cycle is ignored; no grant.

Grant:
- In the grant cycle, latch the owner plus addr, we, wdata and wmask.
- For IF grants: we = 0 and wmask = 0.
- The next state is BUSY_x.
- All dram_* outputs are driven from registers only.
- dram_req is high in every BUSY_x cycle, so the first dram_req is at grant+1.

Completion:
- In BUSY_x with dram_ready = 1: capture dram_rdata and go to RESP.
- In RESP:
  - Pulse the owner's ready for exactly one cycle.
  - if_data = captured[63:32] if latched addr[2] = 1, else captured[31:0].
  - mem_rdata = full 64 bits. For stores, mem_rdata holds its previous value.
  - dram_req is low and no new grant is made; requesters deassert req during this cycle.
  - RESP -> IDLE.
- Minimum latency: request sampled at cycle 0, dram_ready at cycle 1, ready pulse at cycle 2, next grant possible at cycle 3.

Flush:
- if_flush during BUSY_IF sets the discard flag. Flush during RESP with owner IF suppresses if_ready in that cycle.
- The DRAM transaction still completes; the DRAM handshake is never aborted.
- On completion with discard set: go to RESP with if_ready held at 0. Clear discard when leaving RESP.
- if_flush has no effect on MEM transactions.

Other rules:
- dram_ready in IDLE or RESP is ignored.
- if_ready and mem_ready are never high together.
- No back-to-back grant without passing through RESP.

Reset (synchronous):
- State = IDLE; burst_cnt and discard = 0.
- dram_req, dram_we, if_ready, mem_ready and busy = 0.
- dram_wmask, dram_addr, dram_wdata = 0; if_data and mem_rdata = 0.
- Reset mid-transaction abandons it silently; dram_req is low the cycle after reset is sampled.

Test Plan:
- IF alone: if_addr = 0x1004, dram_ready 3 cycles after dram_req, dram_rdata = 0xAAAA_BBBB_1111_2222 -> dram_addr = 0x1004 and dram_req high for 3 cycles; if_ready pulses once with if_data = 0xAAAAB BBB (upper word); no mem_ready.
- Simultaneous if_req and mem_req (mem_we = 1, mem_wmask = 0x0F) -> MEM granted first with dram_we = 1 and dram_wmask = 0x0F; IF granted after the RESP cycle.
- MEM_BURST_MAX = 4, mem_req held continuously with IF pending -> exactly 4 MEM transactions, then 1 IF, then MEM resumes; burst_cnt = 0 after the IF grant.
- if_flush pulsed 1 cycle into BUSY_IF -> dram_req stays high until dram_ready; RESP occurs with if_ready = 0; a following if_req is served normally.
- Reset asserted in BUSY_MEM -> next cycle dram_req = 0, busy = 0, mem_ready = 0; a new mem_req is granted normally.
- dram_ready pulsed while IDLE, plus if_req with if_flush in the same cycle -> no ready pulses, no grant, state stays IDLE.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM port between instruction fetch (IF) and the
// MEM stage. One transaction at a time, MEM priority with a bounded burst so IF
// cannot starve, and stale fetch responses are dropped after a pipeline flush.
module dram_port_arbiter #(
    parameter int unsigned MEM_BURST_MAX = 4,
    parameter int unsigned ADDR_W        = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_wdata,
    input  logic [7:0]        mem_wmask,
    output logic [63:0]       mem_rdata,
    output logic              mem_ready,
    output logic              dram_req,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [63:0]       dram_wdata,
    output logic [7:0]        dram_wmask,
    input  logic [63:0]       dram_rdata,
    input  logic              dram_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MEM_BURST_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               owner_if;
    logic               discard;
    logic [CNT_W-1:0]   burst_cnt;
    logic               grant_mem;
    logic               grant_if;
    logic               if_valid;
    logic               burst_full;

    // A fetch request raised together with a flush is already stale.
    assign if_valid   = if_req & ~if_flush;
    assign burst_full = (burst_cnt == CNT_W'(MEM_BURST_MAX));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and arbitration; grants are only made from IDLE.
    always_comb begin
        next_state = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req && !(if_valid && burst_full)) begin
                    grant_mem  = 1'b1;
                    next_state = S_BUSY_MEM;
                end else if (if_valid) begin
                    grant_if   = 1'b1;
                    next_state = S_BUSY_IF;
                end
            end
            S_BUSY_IF, S_BUSY_MEM: begin
                if (dram_ready) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Requester-side strobes decoded from the registered state.
    always_comb begin
        busy      = (state != S_IDLE);
        mem_ready = (state == S_RESP) && !owner_if;
        if_ready  = (state == S_RESP) && owner_if && !discard && !if_flush;
    end

    // Registered DRAM handshake, latched request, burst counter and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dram_req   <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_wmask <= '0;
            owner_if   <= 1'b0;
            discard    <= 1'b0;
            burst_cnt  <= '0;
            if_data    <= '0;
            mem_rdata  <= '0;
        end else begin
            dram_req <= (next_state == S_BUSY_IF) || (next_state == S_BUSY_MEM);

            if (grant_mem) begin
                owner_if   <= 1'b0;
                dram_addr  <= mem_addr;
                dram_we    <= mem_we;
                dram_wdata <= mem_wdata;
                dram_wmask <= mem_we ? mem_wmask : 8'h00;
            end else if (grant_if) begin
                owner_if   <= 1'b1;
                dram_addr  <= if_addr;
                dram_we    <= 1'b0;
                dram_wdata <= '0;
                dram_wmask <= 8'h00;
            end

            // Only MEM wins over a live fetch extend the burst; anything else restarts it.
            if (state == S_IDLE) begin
                if (grant_mem && if_valid) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                    burst_cnt <= '0;
                end
            end

            if (state == S_BUSY_IF && if_flush) begin
                discard <= 1'b1;
            end else if (state == S_RESP) begin
                discard <= 1'b0;
            end

            if (state == S_BUSY_IF && dram_ready) begin
                if_data <= dram_addr[2] ? dram_rdata[63:32] : dram_rdata[31:0];
            end
            if (state == S_BUSY_MEM && dram_ready && !dram_we) begin
                mem_rdata <= dram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

    localparam int unsigned MAXB = 4;
    localparam int unsigned AW   = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [31:0]   if_data;
    logic          if_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wmask;
    logic [63:0]   mem_rdata;
    logic          mem_ready;
    logic          dram_req;
    logic          dram_we;
    logic [AW-1:0] dram_addr;
    logic [63:0]   dram_wdata;
    logic [7:0]    dram_wmask;
    logic [63:0]   dram_rdata;
    logic          dram_ready;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    dram_port_arbiter #(.MEM_BURST_MAX(MAXB), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask),
        .dram_rdata(dram_rdata), .dram_ready(dram_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit            granted;
        int            wait_cyc;
        logic [AW-1:0] addr;
        logic          we;
        logic [63:0]   wdata;
        logic [7:0]    wmask;
        int            req_cyc;
        bit            req_in_resp;
        int            if_pulses;
        int            mem_pulses;
        bit            both;
        logic [31:0]   if_data;
        logic [63:0]   mem_rdata;
        bit            busy_after;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the DRAM for one transaction and records what the requesters saw.
    // flush_at = BUSY cycle (1-based) in which a one-cycle flush is raised; 0 = none.
    task automatic serve(input int lat, input logic [63:0] rd, input int flush_at,
                         input bit flush_resp, output obs_t o);
        o.granted = 0; o.wait_cyc = 0; o.addr = '0; o.we = 0; o.wdata = '0;
        o.wmask = '0; o.req_cyc = 0; o.req_in_resp = 0; o.if_pulses = 0;
        o.mem_pulses = 0; o.both = 0; o.if_data = '0; o.mem_rdata = '0;
        o.busy_after = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            o.wait_cyc++;
            if (dram_req) begin
                o.granted = 1;
                break;
            end
        end
        if (!o.granted) return;
        o.addr = dram_addr; o.we = dram_we; o.wdata = dram_wdata; o.wmask = dram_wmask;
        o.req_cyc = 1;
        for (int k = 1; k <= lat; k++) begin
            if (if_ready) o.if_pulses++;
            if (mem_ready) o.mem_pulses++;
            if (k == flush_at) begin if_flush = 1'b1; if_req = 1'b0; end
            if (k == lat) begin dram_ready = 1'b1; dram_rdata = rd; end
            tick();
            if_flush   = 1'b0;
            dram_ready = 1'b0;
            dram_rdata = {32'($urandom), 32'($urandom)};
            if (k < lat && dram_req) o.req_cyc++;
        end
        o.req_in_resp = dram_req;
        if (flush_resp) begin if_flush = 1'b1; if_req = 1'b0; #1; end
        if (if_ready) o.if_pulses++;
        if (mem_ready) o.mem_pulses++;
        if (if_ready && mem_ready) o.both = 1;
        o.if_data = if_data; o.mem_rdata = mem_rdata;
        tick();
        if_flush = 1'b0;
        if (if_ready) o.if_pulses++;
        if (mem_ready) o.mem_pulses++;
        o.busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (dram_req !== 1'b0) begin miscompares++; $display("FAIL reset dram_req got %b want 0", dram_req); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
        vectors++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset ready got %b%b want 00", if_ready, mem_ready); end
        vectors++; if (dram_we !== 1'b0 || dram_wmask !== 8'h00) begin miscompares++; $display("FAIL reset we/wmask got %b/%h want 0/00", dram_we, dram_wmask); end
        vectors++; if (dram_addr !== '0 || dram_wdata !== '0) begin miscompares++; $display("FAIL reset addr/wdata got %h/%h want 0/0", dram_addr, dram_wdata); end
        vectors++; if (if_data !== 32'h0 || mem_rdata !== 64'h0) begin miscompares++; $display("FAIL reset rdata got %h/%h want 0/0", if_data, mem_rdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_if_alone();
        obs_t o;
        if_req = 1'b1; if_addr = 64'h1004;
        serve(3, 64'hAAAA_BBBB_1111_2222, 0, 0, o);
        if_req = 1'b0;
        vectors++; if (o.wait_cyc !== 1) begin miscompares++; $display("FAIL if_alone grant_latency got %0d want 1", o.wait_cyc); end
        vectors++; if (o.addr !== 64'h1004) begin miscompares++; $display("FAIL if_alone addr got %h want 1004", o.addr); end
        vectors++; if (o.we !== 1'b0 || o.wmask !== 8'h00) begin miscompares++; $display("FAIL if_alone we/wmask got %b/%h want 0/00", o.we, o.wmask); end
        vectors++; if (o.req_cyc !== 3) begin miscompares++; $display("FAIL if_alone req_cycles got %0d want 3", o.req_cyc); end
        vectors++; if (o.req_in_resp !== 1'b0) begin miscompares++; $display("FAIL if_alone req_in_resp got 1 want 0"); end
        vectors++; if (o.if_pulses !== 1 || o.mem_pulses !== 0) begin miscompares++; $display("FAIL if_alone pulses got if=%0d mem=%0d want 1/0", o.if_pulses, o.mem_pulses); end
        vectors++; if (o.if_data !== 32'hAAAA_BBBB) begin miscompares++; $display("FAIL if_alone if_data got %h want aaaabbbb", o.if_data); end
        vectors++; if (o.busy_after !== 1'b0) begin miscompares++; $display("FAIL if_alone busy_after got 1 want 0"); end
    endtask

    task automatic test_priority();
        obs_t o;
        logic [63:0] prev_rdata;
        prev_rdata = mem_rdata;
        if_req = 1'b1; if_addr = 64'h2000;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h3008;
        mem_wdata = 64'h0123_4567_89AB_CDEF; mem_wmask = 8'h0F;
        serve(2, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, o);
        mem_req = 1'b0; mem_we = 1'b0;
        vectors++; if (o.addr !== 64'h3008) begin miscompares++; $display("FAIL priority mem_first addr got %h want 3008", o.addr); end
        vectors++; if (o.we !== 1'b1 || o.wmask !== 8'h0F) begin miscompares++; $display("FAIL priority store we/wmask got %b/%h want 1/0f", o.we, o.wmask); end
        vectors++; if (o.wdata !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL priority wdata got %h want 0123456789abcdef", o.wdata); end
        vectors++; if (o.mem_pulses !== 1 || o.if_pulses !== 0) begin miscompares++; $display("FAIL priority mem pulses got mem=%0d if=%0d want 1/0", o.mem_pulses, o.if_pulses); end
        vectors++; if (o.mem_rdata !== prev_rdata) begin miscompares++; $display("FAIL priority store_keeps_rdata got %h want %h", o.mem_rdata, prev_rdata); end
        serve(1, 64'h5555_6666_7777_8888, 0, 0, o);
        if_req = 1'b0;
        vectors++; if (o.wait_cyc !== 1 || o.addr !== 64'h2000) begin miscompares++; $display("FAIL priority if_second got wait=%0d addr=%h want 1/2000", o.wait_cyc, o.addr); end
        vectors++; if (o.if_pulses !== 1 || o.if_data !== 32'h7777_8888) begin miscompares++; $display("FAIL priority if_data got n=%0d %h want 1/77778888", o.if_pulses, o.if_data); end
    endtask

    task automatic test_burst();
        obs_t o;
        logic [AW-1:0] exp_addr;
        logic [63:0]   rd;
        bit            exp_if;
        mem_req = 1'b1; mem_we = 1'b0; if_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_addr = 64'h8000 + 64'(i * 8);
            if_addr  = 64'h4000 + 64'(i * 4);
            exp_if   = (i % (MAXB + 1)) == MAXB;
            exp_addr = exp_if ? if_addr : mem_addr;
            rd = {32'($urandom), 32'($urandom)};
            serve(1, rd, 0, 0, o);
            vectors++; if (o.addr !== exp_addr) begin miscompares++; $display("FAIL burst step%0d addr got %h want %h", i, o.addr, exp_addr); end
            vectors++; if (o.if_pulses !== (exp_if ? 1 : 0) || o.mem_pulses !== (exp_if ? 0 : 1)) begin miscompares++; $display("FAIL burst step%0d owner got if=%0d mem=%0d want if=%0d", i, o.if_pulses, o.mem_pulses, exp_if); end
        end
        mem_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_flush();
        obs_t o;
        if_req = 1'b1; if_addr = 64'h40;
        serve(3, 64'h1111_1111_2222_2222, 1, 0, o);
        vectors++; if (o.req_cyc !== 3) begin miscompares++; $display("FAIL flush_busy req_cycles got %0d want 3", o.req_cyc); end
        vectors++; if (o.if_pulses !== 0 || o.mem_pulses !== 0) begin miscompares++; $display("FAIL flush_busy pulses got if=%0d mem=%0d want 0/0", o.if_pulses, o.mem_pulses); end
        vectors++; if (o.busy_after !== 1'b0) begin miscompares++; $display("FAIL flush_busy busy_after got 1 want 0"); end
        if_req = 1'b1; if_addr = 64'h44;
        serve(2, 64'h3333_4444_5555_6666, 0, 0, o);
        if_req = 1'b0;
        vectors++; if (o.if_pulses !== 1 || o.if_data !== 32'h3333_4444) begin miscompares++; $display("FAIL flush_after got n=%0d %h want 1/33334444", o.if_pulses, o.if_data); end
        if_req = 1'b1; if_addr = 64'h48;
        serve(1, 64'h7777_7777_7777_7777, 0, 1, o);
        vectors++; if (o.if_pulses !== 0) begin miscompares++; $display("FAIL flush_resp pulses got %0d want 0", o.if_pulses); end
        if_req = 1'b1; if_addr = 64'h4C;
        serve(1, 64'h9999_AAAA_BBBB_CCCC, 0, 0, o);
        if_req = 1'b0;
        vectors++; if (o.if_pulses !== 1 || o.if_data !== 32'h9999_AAAA) begin miscompares++; $display("FAIL flush_resp_after got n=%0d %h want 1/9999aaaa", o.if_pulses, o.if_data); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   seen;
        seen = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'hC000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dram_req) begin seen = 1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL reset_mid grant got none want dram_req"); end
        tick();
        reset = 1'b1; mem_req = 1'b0;
        tick();
        vectors++; if (dram_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid abandon got req=%b busy=%b want 0/0", dram_req, busy); end
        vectors++; if (mem_ready !== 1'b0 || if_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid ready got %b%b want 00", mem_ready, if_ready); end
        reset = 1'b0;
        tick();
        mem_req = 1'b1; mem_addr = 64'hC100;
        serve(2, 64'hFEED_FACE_CAFE_F00D, 0, 0, o);
        mem_req = 1'b0;
        vectors++; if (o.wait_cyc !== 1 || o.addr !== 64'hC100) begin miscompares++; $display("FAIL reset_mid regrant got wait=%0d addr=%h want 1/c100", o.wait_cyc, o.addr); end
        vectors++; if (o.mem_pulses !== 1 || o.mem_rdata !== 64'hFEED_FACE_CAFE_F00D) begin miscompares++; $display("FAIL reset_mid load got n=%0d %h want 1/feedfacecafef00d", o.mem_pulses, o.mem_rdata); end
    endtask

    task automatic test_idle_noise();
        dram_ready = 1'b1; if_req = 1'b1; if_flush = 1'b1; mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (dram_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_noise cyc%0d got req=%b busy=%b want 0/0", i, dram_req, busy); end
            vectors++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin miscompares++; $display("FAIL idle_noise cyc%0d ready got %b%b want 00", i, if_ready, mem_ready); end
        end
        dram_ready = 1'b0; if_req = 1'b0; if_flush = 1'b0;
        tick();
    endtask

    // Model: MEM wins unless IF has already waited through MAXB MEM grants.
    task automatic test_random();
        obs_t        o;
        int          waited;
        bit          if_pend;
        bit          exp_mem;
        int          lat;
        logic [63:0] rd;
        logic [63:0] last_load;
        logic [31:0] exp_word;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        waited = 0; if_pend = 0; last_load = '0;
        for (int n = 0; n < 60; n++) begin
            if (!if_pend) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = {32'($urandom), 32'($urandom)};
            end
            mem_req   = ($urandom_range(0, 3) != 0);
            mem_we    = ($urandom_range(0, 1) == 1);
            mem_addr  = {32'($urandom), 32'($urandom)};
            mem_wdata = {32'($urandom), 32'($urandom)};
            mem_wmask = 8'($urandom);
            if (!if_req && !mem_req) mem_req = 1'b1;
            exp_mem  = mem_req && !(if_req && waited >= int'(MAXB));
            lat      = $urandom_range(1, 4);
            rd       = {32'($urandom), 32'($urandom)};
            exp_word = if_addr[2] ? rd[63:32] : rd[31:0];
            serve(lat, rd, 0, 0, o);
            vectors++; if (o.wait_cyc !== 1) begin miscompares++; $display("FAIL rand%0d grant_latency got %0d want 1", n, o.wait_cyc); end
            vectors++; if (o.addr !== (exp_mem ? mem_addr : if_addr)) begin miscompares++; $display("FAIL rand%0d addr got %h want %h", n, o.addr, exp_mem ? mem_addr : if_addr); end
            vectors++; if (o.we !== (exp_mem && mem_we) || o.wmask !== ((exp_mem && mem_we) ? mem_wmask : 8'h00)) begin miscompares++; $display("FAIL rand%0d we/wmask got %b/%h", n, o.we, o.wmask); end
            if (exp_mem && mem_we) begin
                vectors++; if (o.wdata !== mem_wdata) begin miscompares++; $display("FAIL rand%0d wdata got %h want %h", n, o.wdata, mem_wdata); end
            end
            vectors++; if (o.req_cyc !== lat || o.req_in_resp !== 1'b0) begin miscompares++; $display("FAIL rand%0d req_cycles got %0d/%b want %0d/0", n, o.req_cyc, o.req_in_resp, lat); end
            vectors++; if (o.mem_pulses !== (exp_mem ? 1 : 0) || o.if_pulses !== (exp_mem ? 0 : 1) || o.both) begin miscompares++; $display("FAIL rand%0d pulses got if=%0d mem=%0d want mem=%0d", n, o.if_pulses, o.mem_pulses, exp_mem); end
            if (exp_mem) begin
                if (!mem_we) last_load = rd;
                vectors++; if (o.mem_rdata !== last_load) begin miscompares++; $display("FAIL rand%0d mem_rdata got %h want %h", n, o.mem_rdata, last_load); end
                waited  = if_req ? waited + 1 : 0;
                if_pend = if_req;
            end else begin
                vectors++; if (o.if_data !== exp_word) begin miscompares++; $display("FAIL rand%0d if_data got %h want %h", n, o.if_data, exp_word); end
                waited  = 0;
                if_pend = 0;
            end
            vectors++; if (o.busy_after !== 1'b0) begin miscompares++; $display("FAIL rand%0d busy_after got 1 want 0", n); end
            mem_req = 1'b0;
            if (!if_pend) if_req = 1'b0;
        end
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        dram_rdata = '0; dram_ready = 1'b0;
        test_reset();
        test_if_alone();
        test_priority();
        test_burst();
        test_flush();
        test_reset_mid();
        test_idle_noise();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
